// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the melody sequencer and the tone generator.
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } seq_state_t;

    localparam int unsigned DEFAULT_TICKS_PER_UNIT = 6000000;

endpackage

// File: rtl/note_sequencer_unit_timer.sv
// Duration-unit prescaler: counts clk cycles while enabled and flags the last tick of each unit.
module unit_timer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] tick_nxt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_UNIT - 1);

    logic [CNT_W-1:0] tick_cnt;

    always_comb begin
        wrap     = en && !clr && (tick_cnt == LAST_TICK);
        tick_nxt = tick_cnt;
        if (clr || wrap) begin
            tick_nxt = '0;
        end else if (en) begin
            tick_nxt = tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_nxt;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: walks the note ROM address with per-note durations, gap, pause and loop control.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DUR_W          = 3,
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT,
    parameter int unsigned GAP_TICKS      = 0,
    parameter bit          AUTOSTART      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DUR_W-1:0]  dur_units,
    output logic [ADDR_W-1:0] note_addr,
    output logic              note_on,
    output logic              busy,
    output logic              beat,
    output logic              done
);

    localparam logic [CNT_W-1:0] GAP_START = CNT_W'(TICKS_PER_UNIT - GAP_TICKS);

    seq_state_t       state;
    logic [DUR_W-1:0] unit_cnt;
    logic [DUR_W-1:0] eff_m1;
    logic [CNT_W-1:0] tick_nxt;
    logic             autoloop;
    logic             restart, run, wrap, boundary, at_last, finish;
    logic             play_nxt, busy_nxt, gap_nxt;

    unit_timer #(
        .CNT_W         (CNT_W),
        .TICKS_PER_UNIT(TICKS_PER_UNIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (run),
        .clr     (restart),
        .tick_nxt(tick_nxt),
        .wrap    (wrap)
    );

    always_comb begin
        restart  = start || stop;
        run      = (state == ST_PLAY) && !pause && !restart;
        eff_m1   = (dur_units == '0) ? '0 : dur_units - DUR_W'(1);
        boundary = wrap && (unit_cnt == eff_m1);
        at_last  = (note_addr == last_addr);
        finish   = boundary && at_last && !loop_en && !autoloop;

        if (stop) begin
            play_nxt = 1'b0;
            busy_nxt = 1'b0;
        end else if (start) begin
            play_nxt = !pause;
            busy_nxt = 1'b1;
        end else if (state == ST_PLAY) begin
            play_nxt = !pause && !finish;
            busy_nxt = !finish;
        end else if (state == ST_PAUSE) begin
            play_nxt = !pause;
            busy_nxt = 1'b1;
        end else begin
            play_nxt = 1'b0;
            busy_nxt = 1'b0;
        end

        // Every path that moves unit_cnt also zeroes the tick, which can never sit in the
        // gap window (GAP_TICKS < TICKS_PER_UNIT), so the held unit_cnt is enough here.
        gap_nxt = (tick_nxt >= GAP_START) && (unit_cnt == eff_m1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= AUTOSTART ? ST_PLAY : ST_IDLE;
            note_addr <= '0;
            unit_cnt  <= '0;
            autoloop  <= AUTOSTART;
            note_on   <= 1'b0;
            busy      <= AUTOSTART;
            beat      <= 1'b0;
            done      <= 1'b0;
        end else begin
            beat    <= wrap;
            done    <= finish;
            busy    <= busy_nxt;
            note_on <= play_nxt && !gap_nxt;
            if (stop) begin
                state     <= ST_IDLE;
                note_addr <= '0;
                unit_cnt  <= '0;
            end else if (start) begin
                state     <= pause ? ST_PAUSE : ST_PLAY;
                note_addr <= '0;
                unit_cnt  <= '0;
                autoloop  <= 1'b0;
            end else begin
                case (state)
                    ST_PLAY: begin
                        if (pause) begin
                            state <= ST_PAUSE;
                        end else if (boundary) begin
                            unit_cnt  <= '0;
                            note_addr <= at_last ? '0 : note_addr + ADDR_W'(1);
                            if (finish) begin
                                state <= ST_IDLE;
                            end
                        end else if (wrap) begin
                            unit_cnt <= unit_cnt + DUR_W'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause) begin
                            state <= ST_PLAY;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
